// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  // Opcodes the fetch stage decodes to pick the next PC
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_MEM = 2'd1,
    PRED     = 2'd2,
    OUT      = 2'd3
  } fetchState_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch stage and its neighbours: the memory
// controller, the branch predictor, decode, and the back-end redirect.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  // Memory controller
  logic              instReq;
  logic [ADDR_W-1:0] instAddr;
  logic              instValid;
  logic [INST_W-1:0] instData;

  // Branch predictor
  logic              predEn;
  logic [ADDR_W-1:0] predPC;
  logic [INST_W-1:0] predInst;
  logic              predOutEn;
  logic              pred;
  logic [ADDR_W-1:0] predAddr;

  // Decode
  logic              outValid;
  logic              outReady;
  logic [INST_W-1:0] outInst;
  logic [ADDR_W-1:0] outPC;
  logic              outPredTaken;

  // Back-end redirect
  logic              flushEn;
  logic [ADDR_W-1:0] flushAddr;

  // Fetch-stage side
  modport master (
    output instReq, instAddr, predEn, predPC, predInst,
           outValid, outInst, outPC, outPredTaken,
    input  instValid, instData, predOutEn, pred, predAddr,
           outReady, flushEn, flushAddr
  );

  // Environment side (memory, predictor, decode, back-end)
  modport slave (
    input  instReq, instAddr, predEn, predPC, predInst,
           outValid, outInst, outPC, outPredTaken,
    output instValid, instData, predOutEn, pred, predAddr,
           outReady, flushEn, flushAddr
  );

endinterface

// File: rtl/fetch_imm_gen.sv
// Sign-extended immediate for control-transfer instructions: B-type
// immediate for conditional branches, J-type immediate otherwise.
module fetch_imm_gen
  import inst_fetch_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] imm
);

  // Pick the immediate layout from the opcode and sign-extend it
  always_comb begin
    imm = '0;
    if (inst[6:0] == OP_BRANCH) begin
      imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    end else begin
      imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Front-end fetch stage: holds the PC, fetches one instruction at a time,
// resolves JAL locally, asks the branch predictor about conditional
// branches, and hands each instruction to decode with its PC and
// predicted direction. A back-end flush redirects the PC at any time.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
)
(
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  inst_fetch_if.master bus
);

  fetchState_t       state, stateD;
  logic [ADDR_W-1:0] pc, pcD;
  logic [ADDR_W-1:0] nextPC, nextPCD;
  logic              dropNext, dropNextD;
  logic              instReq, instReqD;
  logic [ADDR_W-1:0] instAddr, instAddrD;
  logic              predEn, predEnD;
  logic [ADDR_W-1:0] predPC, predPCD;
  logic [INST_W-1:0] predInst, predInstD;
  logic              outValid, outValidD;
  logic [INST_W-1:0] outInst, outInstD;
  logic [ADDR_W-1:0] outPC, outPCD;
  logic              outPredTaken, outPredTakenD;
  logic [ADDR_W-1:0] jumpImm;

  fetch_imm_gen immGen (
    .inst (bus.instData),
    .imm  (jumpImm)
  );

  assign bus.instReq      = instReq;
  assign bus.instAddr     = instAddr;
  assign bus.predEn       = predEn;
  assign bus.predPC       = predPC;
  assign bus.predInst     = predInst;
  assign bus.outValid     = outValid;
  assign bus.outInst      = outInst;
  assign bus.outPC        = outPC;
  assign bus.outPredTaken = outPredTaken;

  // Next-state and next-output logic; everything holds while rdy is low
  always_comb begin
    stateD        = state;
    pcD           = pc;
    nextPCD       = nextPC;
    dropNextD     = dropNext;
    instReqD      = instReq;
    instAddrD     = instAddr;
    predEnD       = predEn;
    predPCD       = predPC;
    predInstD     = predInst;
    outValidD     = outValid;
    outInstD      = outInst;
    outPCD        = outPC;
    outPredTakenD = outPredTaken;

    if (rdy) begin
      predEnD = 1'b0;
      if (bus.flushEn) begin
        pcD       = bus.flushAddr;
        outValidD = 1'b0;
        instReqD  = 1'b0;
        stateD    = FETCH;
        if (state == WAIT_MEM) begin
          dropNextD = !bus.instValid;
        end
      end else begin
        unique case (state)
          FETCH: begin
            instReqD  = 1'b1;
            instAddrD = pc;
            stateD    = WAIT_MEM;
          end
          WAIT_MEM: begin
            if (bus.instValid) begin
              instReqD = 1'b0;
              if (dropNext) begin
                dropNextD = 1'b0;
                stateD    = FETCH;
              end else begin
                outInstD = bus.instData;
                outPCD   = pc;
                if (bus.instData[6:0] == OP_BRANCH) begin
                  predEnD   = 1'b1;
                  predPCD   = pc;
                  predInstD = bus.instData;
                  stateD    = PRED;
                end else if (bus.instData[6:0] == OP_JAL) begin
                  nextPCD       = pc + jumpImm;
                  outPredTakenD = 1'b1;
                  outValidD     = 1'b1;
                  stateD        = OUT;
                end else begin
                  nextPCD       = pc + 32'd4;
                  outPredTakenD = 1'b0;
                  outValidD     = 1'b1;
                  stateD        = OUT;
                end
              end
            end
          end
          PRED: begin
            if (bus.predOutEn) begin
              nextPCD       = bus.predAddr;
              outPredTakenD = bus.pred;
              outValidD     = 1'b1;
              stateD        = OUT;
            end
          end
          OUT: begin
            if (bus.outReady) begin
              outValidD = 1'b0;
              pcD       = nextPC;
              stateD    = FETCH;
            end
          end
          default: begin
            stateD = FETCH;
          end
        endcase
      end
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      nextPC       <= '0;
      dropNext     <= 1'b0;
      instReq      <= 1'b0;
      instAddr     <= '0;
      predEn       <= 1'b0;
      predPC       <= '0;
      predInst     <= '0;
      outValid     <= 1'b0;
      outInst      <= '0;
      outPC        <= '0;
      outPredTaken <= 1'b0;
    end else begin
      state        <= stateD;
      pc           <= pcD;
      nextPC       <= nextPCD;
      dropNext     <= dropNextD;
      instReq      <= instReqD;
      instAddr     <= instAddrD;
      predEn       <= predEnD;
      predPC       <= predPCD;
      predInst     <= predInstD;
      outValid     <= outValidD;
      outInst      <= outInstD;
      outPC        <= outPCD;
      outPredTaken <= outPredTakenD;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: a small instruction memory with fixed
// latency and a registered branch-predictor model surround the DUT.
module tb_inst_fetch;

  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  int compared   = 0;
  int mismatched = 0;

  // Predictor model controls
  logic        bpTaken;
  logic [31:0] bpAddr;
  logic        bpPending;

  // Memory model state
  logic        memBusy;
  int          memCnt;
  logic [31:0] memAddr;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Program image used by the directed scenarios
  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h000: memRead = 32'h00500093;  // addi x1,x0,5
      32'h004: memRead = 32'h00100113;  // addi x2,x0,1
      32'h008: memRead = 32'h100000EF;  // jal  x1,+0x100
      32'h108: memRead = 32'hF09FF06F;  // jal  x0,-0xF8
      32'h010: memRead = 32'h00208863;  // beq  x1,x2,+16
      32'h040: memRead = 32'h00300193;  // addi x3,x0,3
      32'h044: memRead = 32'h00400193;  // addi x3,x0,4
      32'h200: memRead = 32'h00700213;  // addi x4,x0,7
      32'h204: memRead = 32'h00208863;  // beq  x1,x2,+16
      32'h300: memRead = 32'h00900293;  // addi x5,x0,9
      default: memRead = 32'h00000013;  // nop
    endcase
  endfunction

  // Memory controller: accepts a request, answers MEM_LAT cycles later for one cycle
  always @(negedge clk) begin
    if (rst) begin
      bus.instValid = 1'b0;
      bus.instData  = 32'h0;
      memBusy       = 1'b0;
      memCnt        = 0;
      memAddr       = 32'h0;
    end else if (rdy) begin
      if (bus.instValid) begin
        bus.instValid = 1'b0;
      end else if (memBusy) begin
        memCnt = memCnt - 1;
        if (memCnt == 0) begin
          bus.instValid = 1'b1;
          bus.instData  = memRead(memAddr);
          memBusy       = 1'b0;
        end
      end else if (bus.instReq) begin
        memBusy = 1'b1;
        memCnt  = MEM_LAT;
        memAddr = bus.instAddr;
      end
    end
  end

  // Branch predictor: registered one-cycle response to each predEn pulse
  always @(negedge clk) begin
    if (rst) begin
      bus.predOutEn = 1'b0;
      bus.pred      = 1'b0;
      bus.predAddr  = 32'h0;
      bpPending     = 1'b0;
    end else if (rdy) begin
      bus.predOutEn = bpPending;
      if (bpPending) begin
        bus.pred     = bpTaken;
        bus.predAddr = bpAddr;
      end
      bpPending = bus.predEn;
    end
  end

  // Wait for the next instReq and report its address
  task automatic waitReq(output logic [31:0] addr, output bit ok);
    ok   = 1'b0;
    addr = 32'hx;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.instReq) begin
        ok   = 1'b1;
        addr = bus.instAddr;
        break;
      end
    end
  endtask

  // Wait for outValid, counting cycles and predictor pulses on the way
  task automatic waitOut(output int cycles, output int pulses,
                         output logic [31:0] pPC, output logic [31:0] pInst,
                         output bit ok);
    ok     = 1'b0;
    cycles = 0;
    pulses = 0;
    pPC    = 32'hx;
    pInst  = 32'hx;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.predEn) begin
        pulses++;
        pPC   = bus.predPC;
        pInst = bus.predInst;
      end
      if (bus.outValid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reset values on every output
  task automatic test_reset();
    rst           = 1'b1;
    rdy           = 1'b1;
    bus.outReady  = 1'b1;
    bus.flushEn   = 1'b0;
    bus.flushAddr = 32'h0;
    bpTaken       = 1'b0;
    bpAddr        = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({bus.instReq, bus.predEn, bus.outValid, bus.outPredTaken} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {bus.instReq, bus.predEn, bus.outValid, bus.outPredTaken});
    end
    compared++;
    if ({bus.instAddr, bus.outPC, bus.outInst, bus.predPC, bus.predInst} !== 160'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_buses: got %h %h %h %h %h expected all zero",
               bus.instAddr, bus.outPC, bus.outInst, bus.predPC, bus.predInst);
    end
    rst = 1'b0;
  endtask

  // Plain ALU instructions at 0x0 and 0x4, latency and sequential next PC
  task automatic test_sequential();
    logic [31:0] addr, pPC, pInst;
    int cycles, pulses;
    bit ok;
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL first_req: got %h (seen %0d) expected 00000000", addr, ok);
    end
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || cycles != MEM_LAT + 1) begin
      mismatched++;
      $display("[TB] FAIL addi_latency: got %0d (seen %0d) expected %0d", cycles, ok, MEM_LAT + 1);
    end
    compared++;
    if ({bus.outPC, bus.outInst, bus.outPredTaken} !== {32'h0, 32'h00500093, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL addi_out: got pc %h inst %h taken %b expected 0 00500093 0",
               bus.outPC, bus.outInst, bus.outPredTaken);
    end
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h4) begin
      mismatched++;
      $display("[TB] FAIL addi_next: got %h expected 00000004", addr);
    end
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || {bus.outPC, bus.outInst, bus.outPredTaken} !== {32'h4, 32'h00100113, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL addi2_out: got pc %h inst %h taken %b expected 4 00100113 0",
               bus.outPC, bus.outInst, bus.outPredTaken);
    end
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h8) begin
      mismatched++;
      $display("[TB] FAIL addi2_next: got %h expected 00000008", addr);
    end
  endtask

  // JAL forward and backward: resolved locally, never reaches the predictor
  task automatic test_jal();
    logic [31:0] addr, pPC, pInst;
    int cycles, pulses;
    bit ok;
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || pulses != 0) begin
      mismatched++;
      $display("[TB] FAIL jal_no_pred: got %0d pulses (seen %0d) expected 0", pulses, ok);
    end
    compared++;
    if ({bus.outPC, bus.outInst, bus.outPredTaken} !== {32'h8, 32'h100000EF, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL jal_out: got pc %h inst %h taken %b expected 8 100000ef 1",
               bus.outPC, bus.outInst, bus.outPredTaken);
    end
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h108) begin
      mismatched++;
      $display("[TB] FAIL jal_target: got %h expected 00000108", addr);
    end
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || pulses != 0 || {bus.outPC, bus.outPredTaken} !== {32'h108, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL jal_back_out: got pc %h taken %b pulses %0d expected 108 1 0",
               bus.outPC, bus.outPredTaken, pulses);
    end
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h10) begin
      mismatched++;
      $display("[TB] FAIL jal_back_target: got %h expected 00000010", addr);
    end
  endtask

  // Conditional branch predicted taken by the BP
  task automatic test_branch();
    logic [31:0] addr, pPC, pInst;
    int cycles, pulses;
    bit ok;
    bpTaken = 1'b1;
    bpAddr  = 32'h40;
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || pulses != 1 || pPC !== 32'h10 || pInst !== 32'h00208863) begin
      mismatched++;
      $display("[TB] FAIL branch_pred_req: got %0d pulses pc %h inst %h expected 1 10 00208863",
               pulses, pPC, pInst);
    end
    compared++;
    if ({bus.outPC, bus.outInst, bus.outPredTaken} !== {32'h10, 32'h00208863, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL branch_out: got pc %h inst %h taken %b expected 10 00208863 1",
               bus.outPC, bus.outInst, bus.outPredTaken);
    end
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h40) begin
      mismatched++;
      $display("[TB] FAIL branch_target: got %h expected 00000040", addr);
    end
  endtask

  // Decode back-pressure: output held stable, no new fetch
  task automatic test_stall();
    logic [31:0] addr, pPC, pInst;
    int cycles, pulses;
    bit ok;
    bus.outReady = 1'b0;
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || bus.outPC !== 32'h40) begin
      mismatched++;
      $display("[TB] FAIL stall_first: got pc %h (seen %0d) expected 00000040", bus.outPC, ok);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({bus.outValid, bus.instReq, bus.outPC, bus.outInst} !==
          {1'b1, 1'b0, 32'h40, 32'h00300193}) begin
        mismatched++;
        $display("[TB] FAIL stall_hold[%0d]: got valid %b req %b pc %h inst %h expected 1 0 40 00300193",
                 i, bus.outValid, bus.instReq, bus.outPC, bus.outInst);
      end
    end
    bus.outReady = 1'b1;
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h44) begin
      mismatched++;
      $display("[TB] FAIL stall_next: got %h expected 00000044", addr);
    end
  endtask

  // Flush while a memory response is outstanding: stale word is dropped
  task automatic test_flush_wait_mem();
    logic [31:0] addr, pPC, pInst;
    int cycles, pulses;
    bit ok;
    bus.flushEn   = 1'b1;
    bus.flushAddr = 32'h200;
    @(posedge clk); #1;
    bus.flushEn = 1'b0;
    compared++;
    if ({bus.instReq, bus.outValid} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL flush_mem_clear: got req %b valid %b expected 0 0", bus.instReq, bus.outValid);
    end
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h200) begin
      mismatched++;
      $display("[TB] FAIL flush_mem_refetch: got %h expected 00000200", addr);
    end
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || {bus.outPC, bus.outInst, bus.outPredTaken} !== {32'h200, 32'h00700213, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL flush_mem_out: got pc %h inst %h taken %b expected 200 00700213 0",
               bus.outPC, bus.outInst, bus.outPredTaken);
    end
  endtask

  // Flush while waiting for the predictor: late BP response is ignored
  task automatic test_flush_pred();
    logic [31:0] addr, pPC, pInst;
    int cycles, pulses;
    bit ok;
    bpTaken = 1'b1;
    bpAddr  = 32'h80;
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h204) begin
      mismatched++;
      $display("[TB] FAIL flush_pred_fetch: got %h expected 00000204", addr);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.predEn) begin
        ok = 1'b1;
        break;
      end
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL flush_pred_pulse: got no predEn expected one");
    end
    bus.flushEn   = 1'b1;
    bus.flushAddr = 32'h300;
    @(posedge clk); #1;
    bus.flushEn = 1'b0;
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h300) begin
      mismatched++;
      $display("[TB] FAIL flush_pred_refetch: got %h expected 00000300", addr);
    end
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || {bus.outPC, bus.outInst, bus.outPredTaken} !== {32'h300, 32'h00900293, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL flush_pred_out: got pc %h inst %h taken %b expected 300 00900293 0",
               bus.outPC, bus.outInst, bus.outPredTaken);
    end
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h304) begin
      mismatched++;
      $display("[TB] FAIL flush_pred_next: got %h expected 00000304", addr);
    end
  endtask

  // rdy low in OUT freezes everything, including a flush and the handshake
  task automatic test_rdy_freeze();
    logic [31:0] addr, pPC, pInst;
    int cycles, pulses;
    bit ok;
    bus.outReady = 1'b0;
    waitOut(cycles, pulses, pPC, pInst, ok);
    compared++;
    if (!ok || bus.outPC !== 32'h304) begin
      mismatched++;
      $display("[TB] FAIL freeze_first: got pc %h expected 00000304", bus.outPC);
    end
    rdy           = 1'b0;
    bus.outReady  = 1'b1;
    bus.flushEn   = 1'b1;
    bus.flushAddr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({bus.outValid, bus.instReq, bus.outPC, bus.outInst} !==
          {1'b1, 1'b0, 32'h304, 32'h00000013}) begin
        mismatched++;
        $display("[TB] FAIL freeze_hold[%0d]: got valid %b req %b pc %h inst %h expected 1 0 304 00000013",
                 i, bus.outValid, bus.instReq, bus.outPC, bus.outInst);
      end
    end
    bus.flushEn = 1'b0;
    rdy         = 1'b1;
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h308) begin
      mismatched++;
      $display("[TB] FAIL freeze_next: got %h expected 00000308", addr);
    end
  endtask

  // Asynchronous reset in the middle of a fetch
  task automatic test_async_reset();
    logic [31:0] addr;
    bit ok;
    #3;
    rst = 1'b1;
    #1;
    compared++;
    if ({bus.instReq, bus.outValid, bus.instAddr} !== {1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got req %b valid %b addr %h expected 0 0 0",
               bus.instReq, bus.outValid, bus.instAddr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    waitReq(addr, ok);
    compared++;
    if (!ok || addr !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL async_reset_refetch: got %h expected 00000000", addr);
    end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] inst_fetch directed test start");
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_stall();
    test_flush_wait_mem();
    test_flush_pred();
    test_rdy_freeze();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
